dt_event_scheduler: RTL and testbench
=====================================

// Module: dt_event_scheduler
// PURPOSE
// - Upstream feeder of the emulator time manager: queues absolute event times and drives one dt_req lane.
// - dt_req = distance from the current emu_time to the oldest queued event, clamped to dt_max.
//   The time manager's min-reduction therefore lands emu_time exactly on each event.
// - Pops the event and pulses event_fire in the cycle emu_time reaches the head entry.
// PARAMETERS
// - width       32  bit width of dt_req (signed, matches the time manager's dt width)
// - time_width  40  bit width of emu_time and stored event times (signed)
// - depth       8   queue entries; power of 2, >= 2
// - dt_max      -1  largest step requested; -1 selects 2**(width-1)-1
// PORTS
// - emu_clk      in   1           emulator clock; all state on rising edge
// - emu_rst_n    in   1           synchronous reset, active low
// - sched_valid  in   1           producer offers sched_time
// - sched_ready  out  1           queue can accept; = !full
// - sched_time   in   time_width  absolute event time to schedule
// - emu_time     in   time_width  registered emulation time from the time manager
// - dt_req       out  width       requested step, combinational from state and emu_time
// - event_fire   out  1           head event consumed this cycle
// - event_time   out  time_width  head entry time; valid when event_fire=1
// - count        out  $clog2(depth)+1  occupied entries
// - err_order    out  1           sticky: accepted push was older than the previous push
// - err_late     out  1           sticky: an event fired with head < emu_time
// BEHAVIOUR
// - Reset (emu_rst_n=0 at an edge): queue empty, count=0, err_order=0, err_late=0.
//   last_push_time=0. Reset mid-operation discards all entries with no event_fire.
// - Push: transfer occurs when sched_valid && sched_ready at an edge. The entry is visible at head one cycle later.
// - Order check: if sched_time < last_push_time, the transfer still completes.
//   The entry is dropped (count unchanged) and err_order is set. Otherwise it is written and last_push_time=sched_time.
// - Full: sched_ready=0 when count==depth. A pop in the same cycle does not raise ready (no push-through).
// - dt_req, computed in time_width+1 bits: diff = head - emu_time.
//   - empty               -> dt_req = dt_max
//   - diff <= 0           -> dt_req = 0 (zero step; event consumed, time holds one cycle)
//   - 0 < diff <= dt_max  -> dt_req = diff
//   - diff > dt_max       -> dt_req = dt_max
//   dt_req is never negative. No register sits between emu_time and dt_req, so the step is exact every cycle.
// - Fire: event_fire = !empty && head <= emu_time (combinational).
//   - The head pops at that edge; the next entry becomes head the following cycle.
//   - One pop per cycle max; equal times fire on consecutive cycles with dt_req=0.
//   - head < emu_time at fire also sets err_late. A push with a past time therefore fires late, not lost.
// - Simultaneous push and pop: both occur; count unchanged; a push into empty never fires in its own cycle.
// - Queue is a circular buffer; rd/wr pointers wrap mod depth; count distinguishes full from empty.
// - Sticky errors clear only on reset.
// TESTING
// - Reset, empty queue, width=32 -> dt_req=2147483647, sched_ready=1, event_fire=0, count=0.
// - Push 100 with emu_time=0, emu_dt=dt_req, closed loop -> dt_req=100.
//   Next cycle emu_time=100, event_fire=1, event_time=100, dt_req=0. Then dt_req returns to dt_max.
// - dt_max=16, push 50 at time 0 -> emu_time steps 0,16,32,48,50; fire at 50.
// - Push 10,10,30 -> fires at 10 on two consecutive cycles (second with dt_req=0), then at 30; count 3->0.
// - Fill 8 entries -> sched_ready=0. Pop plus offered push same cycle -> no push; ready=1 next cycle.
// - Push 40 then 20 -> 20 dropped, err_order=1, count=1.
//   Push 5 while emu_time=8 -> fires next cycle, err_late=1.
//   Assert emu_rst_n=0 with entries queued -> count=0, flags 0, no event_fire.

Source files
------------

// File: rtl/dt_event_scheduler_if.sv
// ============================================================================
// dt_event_scheduler_if : producer / time-manager bundle for the event scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface dt_event_scheduler_if #(
  parameter int WIDTH      = 32,
  parameter int TIME_WIDTH = 40,
  parameter int DEPTH      = 8
);
  logic                          sched_valid;
  logic                          sched_ready;
  logic signed [TIME_WIDTH-1:0]  sched_time;
  logic signed [TIME_WIDTH-1:0]  emu_time;
  logic signed [WIDTH-1:0]       dt_req;
  logic                          event_fire;
  logic signed [TIME_WIDTH-1:0]  event_time;
  logic [$clog2(DEPTH):0]        count;
  logic                          err_order;
  logic                          err_late;

  modport master (
    output sched_valid, sched_time, emu_time,
    input  sched_ready, dt_req, event_fire, event_time, count, err_order, err_late
  );

  modport slave (
    input  sched_valid, sched_time, emu_time,
    output sched_ready, dt_req, event_fire, event_time, count, err_order, err_late
  );
endinterface

`default_nettype wire

// File: rtl/dt_event_scheduler.sv
// ============================================================================
// dt_event_scheduler : absolute-time event queue driving one dt_req lane
// Rev 1.0
// ============================================================================
`default_nettype none

module dt_event_scheduler #(
  parameter int WIDTH      = 32,
  parameter int TIME_WIDTH = 40,
  parameter int DEPTH      = 8,
  parameter int DT_MAX     = -1
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst_n,
  dt_event_scheduler_if.slave  sif
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_dw    = TIME_WIDTH + 1;

  localparam logic [WIDTH-1:0] c_dt_auto    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_dt_max     = (DT_MAX < 0) ? c_dt_auto : WIDTH'(DT_MAX);
  localparam logic [c_dw-1:0]  c_dt_max_ext = c_dw'(c_dt_max);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

  logic [TIME_WIDTH-1:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0]            r_rd_ptr;
  logic [c_ptr_w-1:0]            r_wr_ptr;
  logic [c_cnt_w-1:0]            r_count;
  logic signed [TIME_WIDTH-1:0]  r_last_push;
  logic                          r_err_order;
  logic                          r_err_late;

  logic                          w_empty;
  logic                          w_full;
  logic [TIME_WIDTH-1:0]         w_head;
  logic signed [c_dw-1:0]        w_diff;
  logic                          w_fire;
  logic                          w_late;
  logic                          w_push;
  logic                          w_order_bad;
  logic                          w_write;
  logic [WIDTH-1:0]              w_dt_req;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_cnt);
  assign w_head  = r_mem[r_rd_ptr];

  // One extra bit keeps head - emu_time from wrapping at the extremes of the time range.
  assign w_diff  = $signed({w_head[TIME_WIDTH-1], w_head})
                 - $signed({sif.emu_time[TIME_WIDTH-1], sif.emu_time});

  assign w_fire  = !w_empty && (w_diff[c_dw-1] || (w_diff == '0));
  assign w_late  = w_diff[c_dw-1];

  // Readiness depends only on occupancy, so a same-cycle pop never admits a push.
  assign w_push      = sif.sched_valid && !w_full;
  assign w_order_bad = ($signed(sif.sched_time) < r_last_push);
  assign w_write     = w_push && !w_order_bad;

  always_comb begin
    w_dt_req = c_dt_max;
    if (!w_empty) begin
      if (w_fire) begin
        w_dt_req = '0;
      end else if (w_diff > $signed(c_dt_max_ext)) begin
        w_dt_req = c_dt_max;
      end else begin
        w_dt_req = w_diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge emu_clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= sif.sched_time;
    end
  end

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_last_push <= '0;
      r_err_order <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr    <= r_wr_ptr + c_ptr_w'(1);
        r_last_push <= $signed(sif.sched_time);
      end
      if (w_push && w_order_bad) begin
        r_err_order <= 1'b1;
      end
      if (w_fire) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        if (w_late) begin
          r_err_late <= 1'b1;
        end
      end
      case ({w_write, w_fire})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign sif.sched_ready = !w_full;
  assign sif.dt_req      = $signed(w_dt_req);
  assign sif.event_fire  = w_fire;
  assign sif.event_time  = $signed(w_head);
  assign sif.count       = r_count;
  assign sif.err_order   = r_err_order;
  assign sif.err_late    = r_err_late;

endmodule

`default_nettype wire

// File: tb/tb_dt_event_scheduler.sv
// ============================================================================
// tb_dt_event_scheduler : queue-model checker plus directed scenarios
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dt_event_scheduler;

  localparam int     WIDTH      = 32;
  localparam int     TIME_WIDTH = 40;
  localparam int     DEPTH      = 8;
  localparam longint DTMAX      = 64'sd2147483647;

  logic emu_clk   = 1'b0;
  logic emu_rst_n = 1'b0;
  always #5 emu_clk = ~emu_clk;

  dt_event_scheduler_if #(.WIDTH(WIDTH), .TIME_WIDTH(TIME_WIDTH), .DEPTH(DEPTH)) sif ();
  dt_event_scheduler_if #(.WIDTH(WIDTH), .TIME_WIDTH(TIME_WIDTH), .DEPTH(DEPTH)) sif16 ();

  dt_event_scheduler #(.WIDTH(WIDTH), .TIME_WIDTH(TIME_WIDTH), .DEPTH(DEPTH), .DT_MAX(-1)) u_dut (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .sif       (sif.slave)
  );

  dt_event_scheduler #(.WIDTH(WIDTH), .TIME_WIDTH(TIME_WIDTH), .DEPTH(DEPTH), .DT_MAX(16)) u_dut16 (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .sif       (sif16.slave)
  );

  int     n_cmp  = 0;
  int     n_bad  = 0;
  bit     chk_en = 1'b0;
  bit     closed = 1'b0;
  longint emu_t  = 0;
  longint q[$];
  longint last_push = 0;
  bit     m_eo = 1'b0;
  bit     m_el = 1'b0;

  longint e16 [5] = '{0, 16, 32, 48, 50};
  longint d16 [5] = '{16, 16, 16, 2, 0};
  longint t4_fire [5] = '{1, 1, 0, 1, 0};
  longint t4_dt   [5] = '{0, 0, 20, 0, DTMAX};
  longint t4_cnt  [5] = '{3, 2, 1, 1, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: step toward the oldest event, clamp to [0, DTMAX].
  function automatic longint m_dt();
    longint diff;
    if (q.size() == 0) return DTMAX;
    diff = q[0] - emu_t;
    if (diff <= 0) return 0;
    if (diff > DTMAX) return DTMAX;
    return diff;
  endfunction

  function automatic bit m_fire();
    return (q.size() > 0) && (q[0] <= emu_t);
  endfunction

  task automatic model_edge();
    longint ts;
    bit     rdy;
    bit     fire;
    ts   = sif.sched_time;
    rdy  = (q.size() < DEPTH);
    fire = m_fire();
    if (!emu_rst_n) begin
      q.delete();
      last_push = 0;
      m_eo = 1'b0;
      m_el = 1'b0;
    end else begin
      if (fire) begin
        if (q[0] < emu_t) m_el = 1'b1;
        void'(q.pop_front());
      end
      if (sif.sched_valid && rdy) begin
        if (ts < last_push) m_eo = 1'b1;
        else begin
          q.push_back(ts);
          last_push = ts;
        end
      end
    end
  endtask

  task automatic set_emu(input longint t);
    emu_t = t;
    sif.emu_time = t[TIME_WIDTH-1:0];
  endtask

  task automatic step();
    longint d;
    d = m_dt();
    @(posedge emu_clk);
    model_edge();
    #1;
    if (closed) set_emu(emu_t + d);
    #1;
  endtask

  task automatic push(input longint t);
    sif.sched_valid = 1'b1;
    sif.sched_time  = t[TIME_WIDTH-1:0];
    step();
    sif.sched_valid = 1'b0;
  endtask

  task automatic do_reset();
    emu_rst_n = 1'b0;
    step();
    emu_rst_n = 1'b1;
    set_emu(0);
  endtask

  always @(negedge emu_clk) begin
    if (chk_en) begin
      chk("dt_req", sif.dt_req, m_dt());
      chk("sched_ready", sif.sched_ready, q.size() < DEPTH);
      chk("event_fire", sif.event_fire, m_fire());
      if (m_fire()) chk("event_time", sif.event_time, q[0]);
      chk("count", sif.count, q.size());
      chk("err_order", sif.err_order, m_eo);
      chk("err_late", sif.err_late, m_el);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sched_valid   = 1'b0;
    sif.sched_time    = '0;
    sif.emu_time      = '0;
    sif16.sched_valid = 1'b0;
    sif16.sched_time  = '0;
    sif16.emu_time    = '0;

    emu_rst_n = 1'b0;
    step();
    step();
    emu_rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_dt_req", sif.dt_req, 2147483647);
    chk("rst_ready", sif.sched_ready, 1);
    chk("rst_fire", sif.event_fire, 0);
    chk("rst_count", sif.count, 0);

    // Single event, closed loop lands exactly on it
    push(100);
    chk("p100_dt", sif.dt_req, 100);
    chk("p100_model_dt", m_dt(), 100);
    closed = 1'b1;
    step();
    chk("p100_fire", sif.event_fire, 1);
    chk("p100_etime", sif.event_time, 100);
    chk("p100_dt0", sif.dt_req, 0);
    step();
    chk("p100_dtmax", sif.dt_req, 2147483647);
    closed = 1'b0;

    // Clamped steps with dt_max=16
    sif16.sched_valid = 1'b1;
    sif16.sched_time  = 40'sd50;
    step();
    sif16.sched_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif16.emu_time = e16[i][TIME_WIDTH-1:0];
      #1;
      chk("dt16_dt", sif16.dt_req, d16[i]);
      chk("dt16_fire", sif16.event_fire, (i == 4) ? 1 : 0);
      if (i == 4) chk("dt16_etime", sif16.event_time, 50);
      step();
    end
    chk("dt16_count", sif16.count, 0);

    // Equal times fire on consecutive cycles
    do_reset();
    push(10);
    push(10);
    push(30);
    chk("eq_count3", sif.count, 3);
    closed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("eq_fire", sif.event_fire, t4_fire[i]);
      chk("eq_dt", sif.dt_req, t4_dt[i]);
      chk("eq_count", sif.count, t4_cnt[i]);
    end
    closed = 1'b0;

    // Full queue, pop with offered push, then drain across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) push(100 + i);
    chk("full_ready", sif.sched_ready, 0);
    chk("full_count", sif.count, 8);
    set_emu(100);
    sif.sched_valid = 1'b1;
    sif.sched_time  = 40'sd200;
    #1;
    chk("full_pop_ready", sif.sched_ready, 0);
    chk("full_pop_fire", sif.event_fire, 1);
    step();
    sif.sched_valid = 1'b0;
    chk("after_pop_count", sif.count, 7);
    chk("after_pop_ready", sif.sched_ready, 1);
    push(108);
    closed = 1'b1;
    repeat (20) step();
    closed = 1'b0;
    chk("drain_count", sif.count, 0);

    // Order error, late fire, reset discards entries
    do_reset();
    push(40);
    push(20);
    chk("ord_count", sif.count, 1);
    chk("ord_err", sif.err_order, 1);
    do_reset();
    chk("ord_clr", sif.err_order, 0);
    set_emu(8);
    push(5);
    chk("late_fire", sif.event_fire, 1);
    chk("late_etime", sif.event_time, 5);
    chk("late_dt", sif.dt_req, 0);
    chk("late_pre", sif.err_late, 0);
    step();
    chk("late_err", sif.err_late, 1);
    chk("late_count", sif.count, 0);
    push(20);
    push(30);
    chk("pre_rst_count", sif.count, 2);
    emu_rst_n = 1'b0;
    step();
    chk("mid_rst_count", sif.count, 0);
    chk("mid_rst_late", sif.err_late, 0);
    chk("mid_rst_order", sif.err_order, 0);
    chk("mid_rst_fire", sif.event_fire, 0);
    emu_rst_n = 1'b1;
    step();
    chk("post_rst_fire", sif.event_fire, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
